// File: rtl/pong_net_pkg.sv
// Shared constants, keycode-to-command map and TX state encoding for the pong network link.
package pong_net_pkg;

    localparam logic [7:0] PKT_SYNC = 8'hA5;

    localparam logic [7:0] KEY_W    = 8'h1A;
    localparam logic [7:0] KEY_S    = 8'h16;
    localparam logic [7:0] KEY_UP   = 8'h52;
    localparam logic [7:0] KEY_DOWN = 8'h51;

    localparam logic [7:0] CMD_HOLD = 8'h0;
    localparam logic [7:0] CMD_POS  = 8'h1;
    localparam logic [7:0] CMD_NEG  = 8'h2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_SEQ,
        ST_CMD,
        ST_CSUM
    } tx_state_t;

    // Keys belonging to the other player map to hold.
    function automatic logic [7:0] map_keycode(input logic [7:0] kc, input logic is_left);
        logic [7:0] cmd;
        cmd = CMD_HOLD;
        if (is_left) begin
            if (kc == KEY_W)
                cmd = CMD_NEG;
            else if (kc == KEY_S)
                cmd = CMD_POS;
        end else begin
            if (kc == KEY_UP)
                cmd = CMD_NEG;
            else if (kc == KEY_DOWN)
                cmd = CMD_POS;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/frame_edge_sync.sv
// Brings the asynchronous frame clock into the Clk domain and emits a one-cycle
// pulse per falling edge.
module frame_edge_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic fall_pulse
);

    logic sync1;
    logic sync2;
    logic sync2_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            sync2_d    <= 1'b1;
            fall_pulse <= 1'b0;
        end else begin
            sync1      <= frame_clk;
            sync2      <= sync1;
            sync2_d    <= sync2;
            fall_pulse <= sync2_d & ~sync2;
        end
    end

endmodule

// File: rtl/paddle_cmd_tx.sv
// Per-frame paddle command sampler and 4-byte packet transmitter on a valid/ready
// byte stream, with a single-entry pending slot.
module paddle_cmd_tx
    import pong_net_pkg::*;
#(
    parameter int unsigned KEEPALIVE_FRAMES = 30
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       isLeft,
    output logic [7:0] cmd_out,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       tx_last,
    output logic [7:0] drop_count
);

    localparam int CNT_W = (KEEPALIVE_FRAMES > 1) ? $clog2(KEEPALIVE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(KEEPALIVE_FRAMES - 1);

    tx_state_t state, next_state;

    logic             fall_pulse;
    logic [7:0]       mapped;
    logic             enqueue;
    logic             handshake;
    logic             launch;

    logic             first_frame;
    logic [7:0]       last_cmd;
    logic [CNT_W-1:0] frame_cnt;
    logic             pend_full;
    logic [7:0]       pend_cmd;
    logic [6:0]       seq;
    logic [6:0]       pkt_seq;
    logic [7:0]       pkt_cmd;
    logic             pkt_left;
    logic [7:0]       byte1;

    frame_edge_sync u_sync (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .fall_pulse (fall_pulse)
    );

    always_comb begin
        mapped    = map_keycode(keycode, isLeft);
        enqueue   = fall_pulse && (first_frame || (mapped != last_cmd) || (frame_cnt >= CNT_MAX));
        handshake = tx_valid && tx_ready;
        launch    = pend_full && ((state == ST_IDLE) || ((state == ST_CSUM) && handshake));
    end

    // A launch on the same edge as an enqueue frees the slot, so the reload is not a drop.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cmd_out     <= '0;
            drop_count  <= '0;
            first_frame <= 1'b1;
            last_cmd    <= '0;
            frame_cnt   <= '0;
            pend_full   <= 1'b0;
            pend_cmd    <= '0;
            seq         <= '0;
            pkt_seq     <= '0;
            pkt_cmd     <= '0;
            pkt_left    <= 1'b0;
        end else begin
            if (fall_pulse) begin
                cmd_out <= mapped;
                if (enqueue) begin
                    frame_cnt   <= '0;
                    last_cmd    <= mapped;
                    first_frame <= 1'b0;
                end else if (frame_cnt < CNT_MAX) begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end

            if (enqueue) begin
                pend_cmd  <= mapped;
                pend_full <= 1'b1;
                if (pend_full && !launch && (drop_count != '1))
                    drop_count <= drop_count + 1'b1;
            end else if (launch) begin
                pend_full <= 1'b0;
            end

            if (launch) begin
                pkt_seq  <= seq;
                pkt_cmd  <= pend_cmd;
                pkt_left <= isLeft;
                seq      <= seq + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        tx_valid   = 1'b1;
        tx_last    = 1'b0;
        tx_data    = '0;
        byte1      = {pkt_left, pkt_seq};
        case (state)
            ST_IDLE: begin
                tx_valid = 1'b0;
                if (pend_full)
                    next_state = ST_SYNC;
            end
            ST_SYNC: begin
                tx_data = PKT_SYNC;
                if (handshake)
                    next_state = ST_SEQ;
            end
            ST_SEQ: begin
                tx_data = byte1;
                if (handshake)
                    next_state = ST_CMD;
            end
            ST_CMD: begin
                tx_data = pkt_cmd;
                if (handshake)
                    next_state = ST_CSUM;
            end
            ST_CSUM: begin
                tx_data = PKT_SYNC ^ byte1 ^ pkt_cmd;
                tx_last = 1'b1;
                if (handshake)
                    next_state = pend_full ? ST_SYNC : ST_IDLE;
            end
            default: begin
                tx_valid   = 1'b0;
                next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_paddle_cmd_tx.sv
// Self-checking bench for paddle_cmd_tx: key-map table, directed multi-cycle cases
// and randomized frames against a packet-level reference model.
module tb_paddle_cmd_tx;

    localparam int unsigned KA = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_clk = 1'b1;
    logic [7:0] keycode = 8'h00;
    logic       isLeft = 1'b1;
    logic [7:0] cmd_out;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       tx_last;
    logic [7:0] drop_count;

    paddle_cmd_tx #(.KEEPALIVE_FRAMES(KA)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .keycode    (keycode),
        .isLeft     (isLeft),
        .cmd_out    (cmd_out),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_last    (tx_last),
        .drop_count (drop_count)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_fail = 0;
    int rdy_mode = 1;
    int stall_run = 0;

    logic [7:0]  rxb[$];
    logic        rxl[$];
    logic [31:0] expq[$];

    bit         m_first;
    logic [7:0] m_last;
    int         m_cnt;
    int         m_seq;

    typedef struct {
        logic       left;
        logic [7:0] kc;
        logic [7:0] exp_cmd;
    } map_vec_t;

    always @(posedge Clk) begin
        #1;
        case (rdy_mode)
            0: tx_ready = 1'b0;
            1: tx_ready = 1'b1;
            default: begin
                if (stall_run >= 2 || $urandom_range(3) != 0) begin
                    tx_ready = 1'b1;
                    stall_run = 0;
                end else begin
                    tx_ready = 1'b0;
                    stall_run++;
                end
            end
        endcase
    end

    always @(negedge Clk) begin
        if (!Reset && tx_valid && tx_ready) begin
            rxb.push_back(tx_data);
            rxl.push_back(tx_last);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_pkt(input logic left, input int seqn, input logic [7:0] cmd);
        logic [7:0] b1;
        b1 = {left, 7'(seqn % 128)};
        return {8'hA5, b1, cmd, 8'hA5 ^ b1 ^ cmd};
    endfunction

    function automatic logic [7:0] ref_map(input logic left, input logic [7:0] kc);
        if (left)
            return (kc == 8'h1A) ? 8'h2 : (kc == 8'h16) ? 8'h1 : 8'h0;
        return (kc == 8'h52) ? 8'h2 : (kc == 8'h51) ? 8'h1 : 8'h0;
    endfunction

    function automatic void model_frame(input logic left, input logic [7:0] kc);
        logic [7:0] c;
        c = ref_map(left, kc);
        if (m_first || c != m_last || m_cnt >= int'(KA) - 1) begin
            expq.push_back(mk_pkt(left, m_seq, c));
            m_seq   = (m_seq + 1) % 128;
            m_cnt   = 0;
            m_last  = c;
            m_first = 0;
        end else if (m_cnt < int'(KA) - 1) begin
            m_cnt++;
        end
    endfunction

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        rxb.delete();
        rxl.delete();
        expq.delete();
        m_first = 1;
        m_last  = 8'h0;
        m_cnt   = 0;
        m_seq   = 0;
    endtask

    task automatic do_frame(input logic [7:0] kc, input logic left);
        @(posedge Clk);
        #1;
        keycode = kc;
        isLeft  = left;
        repeat (3) @(posedge Clk);
        #1 frame_clk = 1'b0;
        repeat (6) @(posedge Clk);
        #1 frame_clk = 1'b1;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge Clk);
            if (!tx_valid) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: tx_valid still high after 80 cycles");
        end
    endtask

    task automatic compare_packets(input string name);
        logic [31:0] act;
        logic [3:0]  lasts;
        while (expq.size() > 0) begin
            if (rxb.size() < 4) begin
                chk({name, "_missing_bytes"}, rxb.size(), 4);
                expq.delete();
                rxb.delete();
                rxl.delete();
                return;
            end
            for (int b = 0; b < 4; b++) begin
                act   = {act[23:0], rxb.pop_front()};
                lasts = {lasts[2:0], rxl.pop_front()};
            end
            chk({name, "_bytes"}, act, expq.pop_front());
            chk({name, "_last"}, {28'h0, lasts}, 32'h1);
        end
        if (rxb.size() != 0) begin
            chk({name, "_extra_bytes"}, rxb.size(), 0);
            rxb.delete();
            rxl.delete();
        end
    endtask

    initial begin
        map_vec_t vecs[10];
        int n_hs;
        bit seen;
        logic [7:0] kcs[5];

        vecs[0] = '{1'b1, 8'h1A, 8'h2};
        vecs[1] = '{1'b1, 8'h16, 8'h1};
        vecs[2] = '{1'b1, 8'h52, 8'h0};
        vecs[3] = '{1'b1, 8'h51, 8'h0};
        vecs[4] = '{1'b1, 8'h00, 8'h0};
        vecs[5] = '{1'b0, 8'h52, 8'h2};
        vecs[6] = '{1'b0, 8'h51, 8'h1};
        vecs[7] = '{1'b0, 8'h1A, 8'h0};
        vecs[8] = '{1'b0, 8'h16, 8'h0};
        vecs[9] = '{1'b0, 8'h04, 8'h0};

        // Reset state and first-frame packet
        rdy_mode = 1;
        do_reset();
        chk("rst_cmd_out", cmd_out, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_last", tx_last, 0);
        chk("rst_drop", drop_count, 0);
        do_frame(8'h00, 1'b1);
        drain();
        expq.push_back(32'hA5800025);
        compare_packets("first_frame");
        chk("first_cmd_out", cmd_out, 8'h0);

        // Command change then unchanged frame
        do_frame(8'h1A, 1'b1);
        drain();
        expq.push_back(32'hA5810226);
        compare_packets("change");
        do_frame(8'h1A, 1'b1);
        drain();
        chk("unchanged_no_pkt", rxb.size(), 0);
        chk("unchanged_cmd_out", cmd_out, 8'h2);

        // Keepalive with KEEPALIVE_FRAMES = 4
        do_reset();
        for (int f = 1; f <= 5; f++) begin
            do_frame(8'h51, 1'b0);
            drain();
            if (f == 1) expq.push_back(32'hA50001A4);
            if (f == 5) expq.push_back(32'hA50101A5);
            compare_packets("keepalive");
        end
        chk("keepalive_cmd_out", cmd_out, 8'h1);

        // Stalled sink: overwrite pending, then back-to-back release
        rdy_mode = 0;
        do_reset();
        do_frame(8'h16, 1'b1);
        chk("stall_valid", tx_valid, 1);
        chk("stall_data", tx_data, 8'hA5);
        do_frame(8'h1A, 1'b1);
        do_frame(8'h16, 1'b1);
        do_frame(8'h1A, 1'b1);
        chk("stall_data_hold", tx_data, 8'hA5);
        chk("stall_drop", drop_count, 2);
        expq.push_back(mk_pkt(1'b1, 0, 8'h1));
        expq.push_back(mk_pkt(1'b1, 1, 8'h2));
        rdy_mode = 1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (tx_valid && tx_ready) begin
                seen = 1;
                break;
            end
        end
        n_hs = 0;
        if (seen) begin
            n_hs = 1;
            for (int i = 0; i < 40; i++) begin
                @(negedge Clk);
                if (!(tx_valid && tx_ready)) break;
                n_hs++;
            end
        end
        chk("b2b_handshakes", n_hs, 8);
        compare_packets("stall_release");

        // Reset during the CMD byte
        do_reset();
        do_frame(8'h1A, 1'b1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_valid && tx_data == 8'h02 && !tx_last) begin
                seen = 1;
                break;
            end
            @(negedge Clk);
        end
        chk("reach_cmd_byte", seen, 1);
        Reset = 1'b1;
        #1;
        chk("abort_valid", tx_valid, 0);
        chk("abort_data", tx_data, 0);
        @(negedge Clk);
        Reset = 1'b0;
        rxb.delete();
        rxl.delete();
        do_frame(8'h16, 1'b1);
        drain();
        expq.push_back(32'hA5800124);
        compare_packets("after_abort");

        // Key-map table
        do_reset();
        foreach (vecs[v]) begin
            do_frame(vecs[v].kc, vecs[v].left);
            chk($sformatf("map_%0d", v), cmd_out, vecs[v].exp_cmd);
            drain();
        end

        // Randomized frames with random sink backpressure
        do_reset();
        rdy_mode = 2;
        kcs[0] = 8'h1A; kcs[1] = 8'h16; kcs[2] = 8'h52; kcs[3] = 8'h51; kcs[4] = 8'h00;
        for (int f = 0; f < 220; f++) begin
            logic [7:0] kc;
            logic       lf;
            lf = 1'($urandom_range(1));
            kc = ($urandom_range(5) == 5) ? 8'($urandom) : kcs[$urandom_range(4)];
            do_frame(kc, lf);
            model_frame(lf, kc);
            chk("rand_cmd_out", cmd_out, ref_map(lf, kc));
            drain();
            compare_packets("rand");
        end
        chk("rand_drop", drop_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/paddle_cmd_tx.md
# paddle_cmd_tx

Local-player paddle command transmitter for the networked pong link. It samples the local keyboard keycode once per game frame and maps it to the paddle command byte (8'h1 = move +Y, 8'h2 = move −Y, 8'h0 = hold) that the paddle block consumes. It emits that command as a 4-byte packet on a valid/ready byte stream toward the Ethernet TX path, so the remote paddle instance receives the same command encoding. It sits between the USB keyboard keycode register and the MAC transmit framer, and also drives the local paddle's keycode input.

## Interface
- KEEPALIVE_FRAMES, 30: maximum frames between packets when the command is unchanged (≥1).
- Clk  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-high.
- frame_clk  in  1  vertical-sync frame clock, asynchronous to Clk; one frame per falling edge.
- keycode  in  8  raw USB HID keycode of the held key, 8'h00 = none.
- isLeft  in  1  1 = left player (W/S keys), 0 = right player (arrow keys); quasi-static.
- cmd_out  out  8  registered paddle command for the local paddle.
- tx_data  out  8  packet byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts byte when tx_valid && tx_ready.
- tx_last  out  1  high with the final byte of a packet.
- drop_count  out  8  saturating count of overwritten pending packets.

## Operation
- Keycode map, left: 8'h1A (W) → 8'h2, 8'h16 (S) → 8'h1. Right: 8'h52 (Up) → 8'h2, 8'h51 (Down) → 8'h1. Any other keycode → 8'h0, including the other player's keys.
- frame_clk passes through a 2-FF synchronizer. A registered falling-edge detect produces fall_pulse, one Clk wide.
- On the edge closing a fall_pulse cycle:
  - cmd_out ← mapped command.
  - Enqueue if any of: first frame since reset, command ≠ last enqueued command, or frame_cnt ≥ KEEPALIVE_FRAMES−1.
  - On enqueue, frame_cnt ← 0. Otherwise frame_cnt increments, saturating at KEEPALIVE_FRAMES−1.
- Pending slot, depth 1, holds {cmd}. If the slot is already full when a new enqueue occurs, the new command overwrites it and drop_count increments (saturating at 255).
- Packet format:
  - byte0 = 8'hA5 (sync)
  - byte1 = {isLeft, seq[6:0]}
  - byte2 = cmd
  - byte3 = byte0 ^ byte1 ^ byte2
- seq is captured when a packet launches, then increments modulo 128. First packet after reset uses seq = 0.
- FSM states:
  - IDLE: if pending is full, move to SYNC and clear pending. Pending is consumed at launch, so a new frame can refill it mid-packet.
  - SYNC → SEQ → CMD → CSUM: each state advances only on tx_valid && tx_ready.
  - CSUM with handshake: go to SYNC if pending is full (back-to-back), else IDLE.
- tx_valid is high in every state except IDLE. tx_last is high only in CSUM.
- tx_data, tx_last and the packet contents (seq, cmd, isLeft) are frozen while tx_valid && !tx_ready.

## Timing
- Reset values:
  - cmd_out = 0, tx_data = 0, tx_valid = 0, tx_last = 0, drop_count = 0.
  - seq = 0, frame_cnt = 0, pending empty, FSM IDLE, synchronizer = 1.
  - first-frame flag set.
- Reset mid-packet aborts immediately. tx_valid drops asynchronously and the partial packet is never resumed.
- Latency: with frame_clk low at Clk edge E1, fall_pulse is high after E3, cmd_out and pending update at E4, and tx_valid rises with 8'hA5 after E5.
- With tx_ready held high, a packet takes exactly 4 cycles, and back-to-back packets have no idle gap.
- If an enqueue and the IDLE launch happen on the same edge, the launch takes the old pending content and the slot reloads with the new command; this is not counted as a drop.
- Keycode is sampled only at the fall_pulse edge; changes between frames are ignored.

## Structure
- Shared package `pong_net_pkg` holds:
  - PKT_SYNC = 8'hA5
  - keycode constants KEY_W, KEY_S, KEY_UP, KEY_DOWN
  - command constants CMD_HOLD/CMD_POS/CMD_NEG (0/1/2)
  - the `tx_state_t` enum, reused by the matching receiver
- One sub-module, `frame_edge_sync`, contains the 2-FF synchronizer and the registered falling-edge pulse.

## Test plan
- Reset, left, keycode 8'h00, tx_ready=1, one frame edge → packet A5,80,00,25 (first-frame send), tx_last on the 4th byte, cmd_out=0.
- Left, keycode 8'h1A across frames 2–3 → frame 2 sends A5,81,02,26; frame 3 sends nothing; cmd_out=8'h2.
- Right, keycode 8'h51 held, KEEPALIVE_FRAMES=4 → packets on frames 1 and 5 only, byte1=8'h00 then 8'h01, cmd 8'h1.
- Left, tx_ready=0 throughout, commands alternate 1/2 over 4 frames → first packet stalls holding 8'hA5; drop_count=2; on release, two packets carry the first and last commands.
- Reset asserted during the CMD byte with tx_ready=1 → tx_valid=0 in the same cycle; the next packet after reset starts with 8'hA5 and seq 0.
- Continuous traffic across 130 packets → seq wraps 7F→00; checksum byte correct on every packet.
